bus_arbiter: RTL

- Shares one external memory bus between two requesters: the instruction-fetch port (IF) and the load/store port (MEM).
- Sits between the fetch/memory stages and the SoC bus.
- Serialises accesses, gives MEM priority, and raises per-port stall requests into the pipeline control block.
- Holds returned data while the pipeline is stalled, and drains accesses that are cancelled by a flush.

---
 rtl/bus_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// Two-port bus arbiter: serialises instruction-fetch and load/store accesses onto one
// external bus (MEM has priority), stalls the waiting port, holds returned data and drains flushed cycles.
module bus_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [5:0]    stall,
  input  logic          flush,
  input  logic          if_ce,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  input  logic          mem_ce,
  input  logic          mem_we,
  input  logic [3:0]    mem_sel,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] mem_rdata,
  output logic          stallreq_if,
  output logic          stallreq_mem,
  output logic          bus_req,
  output logic          bus_we,
  output logic [3:0]    bus_sel,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_ack,
  input  logic [DW-1:0] bus_rdata
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MEM_BUSY = 3'd1,
    IF_BUSY  = 3'd2,
    MEM_HOLD = 3'd3,
    IF_HOLD  = 3'd4,
    DRAIN    = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic          launch_mem, launch_if, bus_clr, latch_mem, latch_if;
  logic [DW-1:0] mem_hold_q, if_hold_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    launch_mem = 1'b0;
    launch_if  = 1'b0;
    bus_clr    = 1'b0;
    latch_mem  = 1'b0;
    latch_if   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush) begin
          if (mem_ce) begin
            launch_mem = 1'b1;
            state_d    = MEM_BUSY;
          end else if (if_ce) begin
            launch_if = 1'b1;
            state_d   = IF_BUSY;
          end
        end
      end
      MEM_BUSY: begin
        // An ack that coincides with a flush completes the cycle but the data is discarded.
        if (bus_ack) begin
          bus_clr = 1'b1;
          if (flush) state_d = IDLE;
          else begin
            latch_mem = 1'b1;
            state_d   = MEM_HOLD;
          end
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      IF_BUSY: begin
        if (bus_ack) begin
          bus_clr = 1'b1;
          if (flush) state_d = IDLE;
          else begin
            latch_if = 1'b1;
            state_d  = IF_HOLD;
          end
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      MEM_HOLD: if (!stall[3] || flush) state_d = IDLE;
      IF_HOLD:  if (!stall[1] || flush) state_d = IDLE;
      DRAIN: begin
        if (bus_ack) begin
          bus_clr = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs stay frozen from launch until the ack edge, then return to zero.
  always_ff @(posedge clk) begin
    if (rst || bus_clr) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_sel   <= 4'b0000;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else if (launch_mem) begin
      bus_req   <= 1'b1;
      bus_we    <= mem_we;
      bus_sel   <= mem_sel;
      bus_addr  <= mem_addr;
      bus_wdata <= mem_wdata;
    end else if (launch_if) begin
      bus_req   <= 1'b1;
      bus_we    <= 1'b0;
      bus_sel   <= 4'b1111;
      bus_addr  <= if_addr;
      bus_wdata <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_hold_q <= '0;
      if_hold_q  <= '0;
    end else begin
      if (latch_mem) mem_hold_q <= bus_rdata;
      if (latch_if)  if_hold_q  <= bus_rdata;
    end
  end

  assign mem_rdata    = (state_q == MEM_HOLD) ? mem_hold_q : '0;
  assign if_rdata     = (state_q == IF_HOLD)  ? if_hold_q  : '0;
  assign stallreq_mem = mem_ce & ~flush & (state_q != MEM_HOLD);
  assign stallreq_if  = if_ce  & ~flush & (state_q != IF_HOLD);

endmodule
